// File: rtl/af6cesrtl_freebitx.sv
// af6cesrtl_freebitx : register-bitmap free-block allocator.
//   Tracks MAXBLK block IDs in an NWORD x NUMBIT bitmap, fills it on
//   activation, accepts released IDs and prefetches free IDs through a
//   PFDEPTH-deep show-ahead FIFO towards the writer.
// Optional feature macro: FREEBIT_WMARK_EN (adds wmclr / blkmin low-watermark).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   active                   enable; low flushes, high starts init
//   wrblkrdy/wrblkget/wrblkid  free-ID handoff (show-ahead FIFO head)
//   rdblkfree/rdblkid        release strobe and ID
//   blknum                   free count (bitmap + pending + FIFO)
//   blkemp, blklow           last-block-taken pulse, low-count level
//   blksame/blksameid        bad release pulse and offending ID
//   blkgap                   get-while-not-ready pulse
//   wmclr/blkmin             (FREEBIT_WMARK_EN) watermark clear / minimum
module af6cesrtl_freebitx #(
  parameter int ADDBLK  = 8,
  parameter int MAXBLK  = 200,
  parameter int ADDBIT  = 4,
  parameter int PFDEPTH = 4,
  parameter int LOWTHR  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  output logic              wrblkrdy,
  input  logic              wrblkget,
  output logic [ADDBLK-1:0] wrblkid,
  input  logic              rdblkfree,
  input  logic [ADDBLK-1:0] rdblkid,
  output logic [ADDBLK:0]   blknum,
  output logic              blkemp,
  output logic              blklow,
  output logic              blksame,
  output logic [ADDBLK-1:0] blksameid,
  output logic              blkgap
`ifdef FREEBIT_WMARK_EN
  ,
  input  logic              wmclr,
  output logic [ADDBLK:0]   blkmin
`endif
);

  localparam int NUMBIT = 1 << ADDBIT;
  localparam int NWORD  = (MAXBLK + NUMBIT - 1) / NUMBIT;
  localparam int SPW    = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int FPW    = (PFDEPTH > 1) ? $clog2(PFDEPTH) : 1;
  localparam int FCW    = $clog2(PFDEPTH + 1);
  localparam logic [SPW-1:0]  SP_LAST = SPW'(NWORD - 1);
  localparam logic [ADDBLK:0] NUM_MAX = (ADDBLK + 1)'(MAXBLK);
  localparam logic [ADDBLK:0] NUM_ONE = (ADDBLK + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;
  state_t r_state, w_state_nx;

  logic              r_active1;
  logic [NUMBIT-1:0] r_bmp    [NWORD];
  logic [NUMBIT-1:0] w_bmp_nx [NWORD];
  logic [SPW-1:0]    r_sptr, w_sptr_nx;
  logic              r_pvld;
  logic [ADDBLK-1:0] r_pid;
  logic [ADDBLK-1:0] r_fifo [PFDEPTH];
  logic [FPW-1:0]    r_wptr, r_rptr;
  logic [FCW-1:0]    r_cnt;
  logic [ADDBLK:0]   r_blknum, w_blknum_nx;
  logic              r_blkemp, r_blklow, r_blksame, r_blkgap;
  logic [ADDBLK-1:0] r_blksameid;

  logic              w_init, w_run, w_rdy, w_get_ok, w_gap;
  logic [31:0]       w_relw;
  logic [ADDBIT-1:0] w_relb, w_sbit;
  logic [NUMBIT-1:0] w_relset, w_sword, w_sclr;
  logic              w_rel_rng, w_relhit, w_rel_ok, w_rel_bad;
  logic              w_scan_en, w_sfound, w_hit;
  logic [ADDBLK-1:0] w_scan_id;

  function automatic logic [FPW-1:0] f_finc(input logic [FPW-1:0] p);
    return (p == FPW'(PFDEPTH - 1)) ? '0 : p + FPW'(1);
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM: next state (r_sptr doubles as the init word pointer)
  always_comb begin
    w_state_nx = r_state;
    if (!r_active1) w_state_nx = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  w_state_nx = S_INIT;
        S_INIT:  if (r_sptr == SP_LAST) w_state_nx = S_RUN;
        S_RUN:   w_state_nx = S_RUN;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_init = 1'b0;
    w_run  = 1'b0;
    case (r_state)
      S_INIT:  w_init = r_active1;
      S_RUN:   w_run  = r_active1;
      default: ;
    endcase
  end

  // Handoff, release and scan decode
  always_comb begin
    w_rdy     = (r_cnt != '0);
    w_get_ok  = w_run && wrblkget && w_rdy;
    w_gap     = w_run && wrblkget && !w_rdy;
    w_relw    = 32'(rdblkid >> ADDBIT);
    w_relb    = rdblkid[ADDBIT-1:0];
    w_relset  = NUMBIT'(1) << w_relb;
    w_rel_rng = (32'(rdblkid) < 32'(MAXBLK));
    w_relhit  = 1'b0;
    w_sword   = '0;
    for (int unsigned w = 0; w < NWORD; w++) begin
      if (w == w_relw)        w_relhit = r_bmp[w][w_relb];
      if (w == 32'(r_sptr))   w_sword  = r_bmp[w];
    end
    w_rel_ok  = w_run && rdblkfree && w_rel_rng && !w_relhit;
    w_rel_bad = w_run && rdblkfree && !(w_rel_rng && !w_relhit);
    w_scan_en = w_run && ((32'(r_cnt) + 32'(r_pvld)) < 32'(PFDEPTH));
    w_sfound  = 1'b0;
    w_sbit    = '0;
    for (int unsigned b = 0; b < NUMBIT; b++) begin
      if (!w_sfound && w_sword[b]) begin
        w_sfound = 1'b1;
        w_sbit   = ADDBIT'(b);
      end
    end
    w_hit     = w_scan_en && w_sfound;
    w_scan_id = ADDBLK'((32'(r_sptr) << ADDBIT) | 32'(w_sbit));
    w_sclr    = w_hit ? (NUMBIT'(1) << w_sbit) : '0;
  end

  // Bitmap, scan pointer and free count next values. The scanner works on
  // the pre-release word, so a bit released this cycle is not picked now.
  always_comb begin
    for (int unsigned w = 0; w < NWORD; w++) begin
      w_bmp_nx[w] = r_bmp[w];
      if (!r_active1) w_bmp_nx[w] = '0;
      else if (w_init && (w == 32'(r_sptr))) begin
        for (int unsigned b = 0; b < NUMBIT; b++)
          w_bmp_nx[w][b] = ((w * NUMBIT + b) < MAXBLK);
      end else if (w_run) begin
        if (w == 32'(r_sptr))       w_bmp_nx[w] = w_bmp_nx[w] & ~w_sclr;
        if (w_rel_ok && w == w_relw) w_bmp_nx[w] = w_bmp_nx[w] | w_relset;
      end
    end

    w_sptr_nx = r_sptr;
    if (!r_active1 || r_state == S_IDLE) w_sptr_nx = '0;
    else if (w_init || (w_scan_en && !w_sfound))
      w_sptr_nx = (r_sptr == SP_LAST) ? '0 : r_sptr + SPW'(1);

    w_blknum_nx = r_blknum;
    if (!r_active1) w_blknum_nx = '0;
    else if (w_init && r_sptr == SP_LAST) w_blknum_nx = NUM_MAX;
    else if (w_rel_ok && !w_get_ok && r_blknum < NUM_MAX)
      w_blknum_nx = r_blknum + NUM_ONE;
    else if (w_get_ok && !w_rel_ok && r_blknum != '0)
      w_blknum_nx = r_blknum - NUM_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active1   <= 1'b0;
      for (int unsigned w = 0; w < NWORD; w++) r_bmp[w] <= '0;
      r_sptr      <= '0;
      r_blknum    <= '0;
      r_pvld      <= 1'b0;
      r_pid       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_blkemp    <= 1'b0;
      r_blklow    <= 1'b0;
      r_blksame   <= 1'b0;
      r_blksameid <= '0;
      r_blkgap    <= 1'b0;
    end else begin
      r_active1 <= active;
      for (int unsigned w = 0; w < NWORD; w++) r_bmp[w] <= w_bmp_nx[w];
      r_sptr    <= w_sptr_nx;
      r_blknum  <= w_blknum_nx;
      if (!w_run) begin
        // Also drops a pending push when active falls
        r_pvld <= 1'b0;
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        r_pvld <= w_hit;
        if (w_hit)    r_pid  <= w_scan_id;
        if (r_pvld)   r_wptr <= f_finc(r_wptr);
        if (w_get_ok) r_rptr <= f_finc(r_rptr);
        r_cnt <= r_cnt + FCW'(r_pvld) - FCW'(w_get_ok);
      end
      r_blkemp  <= w_get_ok && (r_blknum == NUM_ONE);
      r_blksame <= w_rel_bad;
      if (w_rel_bad) r_blksameid <= rdblkid;
      r_blkgap  <= w_gap;
      r_blklow  <= (w_state_nx == S_RUN) && (32'(w_blknum_nx) < 32'(LOWTHR));
    end
  end

  always_ff @(posedge clk) begin
    if (w_run && r_pvld) r_fifo[r_wptr] <= r_pid;
  end

`ifdef FREEBIT_WMARK_EN
  logic [ADDBLK:0] r_blkmin;
  always_ff @(posedge clk) begin
    if (rst || w_state_nx != S_RUN) r_blkmin <= '0;
    else if (r_state != S_RUN)      r_blkmin <= w_blknum_nx;
    else if (wmclr)                 r_blkmin <= r_blknum;
    else if (w_blknum_nx < r_blkmin) r_blkmin <= w_blknum_nx;
  end
  assign blkmin = r_blkmin;
`endif

  assign wrblkrdy  = w_rdy;
  assign wrblkid   = w_rdy ? r_fifo[r_rptr] : '0;
  assign blknum    = r_blknum;
  assign blkemp    = r_blkemp;
  assign blklow    = r_blklow;
  assign blksame   = r_blksame;
  assign blksameid = r_blksameid;
  assign blkgap    = r_blkgap;

endmodule
